// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, IR ownership,
// ALU operand/op selection, write-back, PC update and imem/dmem handshakes.

package mc_control_unit_pkg;

    localparam int unsigned ALU_OP_BITS = 6;

    // ALU operation encodings
    localparam logic [ALU_OP_BITS-1:0] ALU_ADD  = 6'd0;
    localparam logic [ALU_OP_BITS-1:0] ALU_SUB  = 6'd1;
    localparam logic [ALU_OP_BITS-1:0] ALU_AND  = 6'd2;
    localparam logic [ALU_OP_BITS-1:0] ALU_OR   = 6'd3;
    localparam logic [ALU_OP_BITS-1:0] ALU_XOR  = 6'd4;
    localparam logic [ALU_OP_BITS-1:0] ALU_NOR  = 6'd5;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLT  = 6'd6;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLTU = 6'd7;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ALU_OP_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    input  logic [XLEN-1:0]     reg_out_1,
    input  logic [XLEN-1:0]     reg_out_2,
    input  logic                alu_zero,
    output logic [XLEN-1:0]     alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [REG_AW-1:0]   reg_w,
    output logic                reg_write_en,
    output logic                wb_sel,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    output logic                pc_write,
    output logic                pc_src,
    output logic                illegal,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        B_REG  = 2'd0,
        B_SEXT = 2'd1,
        B_ZEXT = 2'd2,
        B_LUI  = 2'd3
    } bsel_e;

    state_e state;
    state_e state_nxt;

    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    logic                   dec_legal;
    logic                   dec_rtype;
    logic                   dec_load;
    logic                   dec_store;
    logic                   dec_branch;
    logic                   dec_bne;
    bsel_e                  dec_bsel;
    logic [ALU_OP_BITS-1:0] dec_op;
    logic [XLEN-1:0]        operand_b;

    // rs data goes straight to ALU A outside this block; rs index is not needed here
    logic unused_bits;
    assign unused_bits = ^{reg_out_1, ir[25:21]};

    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];
    assign state_dbg = state;

    // State register and instruction register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && imem_ready) begin
                ir <= imem_rdata;
            end
        end
    end

    // Instruction classification from the IR
    always_comb begin
        dec_legal  = 1'b1;
        dec_rtype  = 1'b0;
        dec_load   = 1'b0;
        dec_store  = 1'b0;
        dec_branch = 1'b0;
        dec_bne    = 1'b0;
        dec_bsel   = B_SEXT;
        dec_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                dec_rtype = 1'b1;
                dec_bsel  = B_REG;
                case (funct)
                    FN_ADD, FN_ADDU: dec_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_op = ALU_SUB;
                    FN_AND:          dec_op = ALU_AND;
                    FN_OR:           dec_op = ALU_OR;
                    FN_XOR:          dec_op = ALU_XOR;
                    FN_NOR:          dec_op = ALU_NOR;
                    FN_SLT:          dec_op = ALU_SLT;
                    FN_SLTU:         dec_op = ALU_SLTU;
                    default:         dec_legal = 1'b0;
                endcase
            end
            OP_BEQ: begin
                dec_branch = 1'b1;
                dec_bsel   = B_REG;
                dec_op     = ALU_SUB;
            end
            OP_BNE: begin
                dec_branch = 1'b1;
                dec_bne    = 1'b1;
                dec_bsel   = B_REG;
                dec_op     = ALU_SUB;
            end
            OP_ADDI, OP_ADDIU: dec_op = ALU_ADD;
            OP_SLTI:           dec_op = ALU_SLT;
            OP_SLTIU:          dec_op = ALU_SLTU;
            OP_ANDI: begin
                dec_bsel = B_ZEXT;
                dec_op   = ALU_AND;
            end
            OP_ORI: begin
                dec_bsel = B_ZEXT;
                dec_op   = ALU_OR;
            end
            OP_XORI: begin
                dec_bsel = B_ZEXT;
                dec_op   = ALU_XOR;
            end
            OP_LUI: begin
                dec_bsel = B_LUI;
                dec_op   = ALU_ADD;
            end
            OP_LW:   dec_load  = 1'b1;
            OP_SW:   dec_store = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    // Operand B: register data or the extended immediate
    always_comb begin
        operand_b = '0;
        case (dec_bsel)
            B_REG:   operand_b = reg_out_2;
            B_SEXT:  operand_b = XLEN'($signed(ir[15:0]));
            B_ZEXT:  operand_b = XLEN'(ir[15:0]);
            B_LUI:   operand_b = XLEN'($signed({ir[15:0], 16'h0000}));
            default: operand_b = '0;
        endcase
    end

    // Destination register: rd for R-type, rt otherwise
    always_comb begin
        reg_w = dec_rtype ? REG_AW'(ir[15:11]) : REG_AW'(ir[20:16]);
    end

    // Next-state and output decode; reset forces the idle output set
    always_comb begin
        state_nxt    = state;
        imem_req     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        reg_write_en = 1'b0;
        wb_sel       = 1'b0;
        illegal      = 1'b0;
        alu_op       = ALU_OP_W'(ALU_ADD);
        alu_b        = '0;

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    illegal   = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op = ALU_OP_W'(dec_op);
                alu_b  = operand_b;
                if (dec_branch) begin
                    if (alu_zero ^ dec_bne) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    state_nxt = S_FETCH;
                end else if (dec_load || dec_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                alu_op   = ALU_OP_W'(dec_op);
                alu_b    = operand_b;
                dmem_req = 1'b1;
                dmem_we  = dec_store;
                wb_sel   = dec_load;
                if (dmem_ready) begin
                    state_nxt = dec_store ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                alu_op       = ALU_OP_W'(dec_op);
                alu_b        = operand_b;
                wb_sel       = dec_load;
                reg_write_en = (reg_w != '0);
                state_nxt    = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        if (!rst_n) begin
            state_nxt    = S_FETCH;
            imem_req     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 1'b0;
            dmem_req     = 1'b0;
            dmem_we      = 1'b0;
            reg_write_en = 1'b0;
            wb_sel       = 1'b0;
            illegal      = 1'b0;
            alu_op       = ALU_OP_W'(ALU_ADD);
            alu_b        = '0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed self-checking bench for mc_control_unit (XLEN = 64).

module tb_mc_control_unit;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned ALU_OP_W = 6;

    // Expected encodings written out independently of the design
    localparam logic [63:0] E_ADD  = 64'd0;
    localparam logic [63:0] E_SUB  = 64'd1;
    localparam logic [63:0] E_OR   = 64'd3;
    localparam logic [63:0] E_SLTU = 64'd7;

    localparam logic [63:0] S_FETCH  = 64'd0;
    localparam logic [63:0] S_DECODE = 64'd1;
    localparam logic [63:0] S_EXEC   = 64'd2;
    localparam logic [63:0] S_MEM    = 64'd3;
    localparam logic [63:0] S_WB     = 64'd4;

    logic                clk;
    logic                rst_n;
    logic                imem_req;
    logic                imem_ready;
    logic [31:0]         imem_rdata;
    logic [XLEN-1:0]     reg_out_1;
    logic [XLEN-1:0]     reg_out_2;
    logic                alu_zero;
    logic [XLEN-1:0]     alu_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [REG_AW-1:0]   reg_w;
    logic                reg_write_en;
    logic                wb_sel;
    logic                dmem_req;
    logic                dmem_we;
    logic                dmem_ready;
    logic                pc_write;
    logic                pc_src;
    logic                illegal;
    logic [2:0]          state_dbg;

    int n_checks;
    int n_errors;

    mc_control_unit #(
        .XLEN    (XLEN),
        .REG_AW  (REG_AW),
        .ALU_OP_W(ALU_OP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .reg_out_1   (reg_out_1),
        .reg_out_2   (reg_out_2),
        .alu_zero    (alu_zero),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .reg_w       (reg_w),
        .reg_write_en(reg_write_en),
        .wb_sel      (wb_sel),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .illegal     (illegal),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in FETCH with zero wait and move into DECODE
    task automatic fetch(input logic [31:0] instr);
        imem_ready = 1'b1;
        imem_rdata = instr;
        #1;
        check("fetch_state", 64'(state_dbg), S_FETCH);
        check("fetch_pc_write", 64'(pc_write), 64'd1);
        cyc();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("decode_state", 64'(state_dbg), S_DECODE);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        reg_out_1  = 64'h1111;
        reg_out_2  = 64'h0;
        alu_zero   = 1'b0;
        dmem_ready = 1'b0;

        // Reset state, with imem_ready high to confirm request gating
        cyc();
        cyc();
        imem_ready = 1'b1;
        #1;
        check("rst_state", 64'(state_dbg), S_FETCH);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_pc_write", 64'(pc_write), 64'd0);
        check("rst_alu_op", 64'(alu_op), E_ADD);
        check("rst_alu_b", 64'(alu_b), 64'd0);

        // Release reset: fetch ADDI $5,$0,-1
        rst_n      = 1'b1;
        imem_rdata = 32'h2005_FFFF;
        #1;
        check("rel_imem_req", 64'(imem_req), 64'd1);
        check("rel_pc_src", 64'(pc_src), 64'd0);
        fetch(32'h2005_FFFF);
        check("addi_dec_illegal", 64'(illegal), 64'd0);
        check("addi_dec_imem_req", 64'(imem_req), 64'd0);
        cyc();
        check("addi_exec_state", 64'(state_dbg), S_EXEC);
        check("addi_alu_b", 64'(alu_b), 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_alu_op", 64'(alu_op), E_ADD);
        check("addi_exec_we", 64'(reg_write_en), 64'd0);
        cyc();
        check("addi_wb_state", 64'(state_dbg), S_WB);
        check("addi_reg_w", 64'(reg_w), 64'd5);
        check("addi_we", 64'(reg_write_en), 64'd1);
        check("addi_wb_sel", 64'(wb_sel), 64'd0);
        cyc();
        check("addi_back_fetch", 64'(state_dbg), S_FETCH);

        // ORI $3,$3,0x8000: zero-extended immediate
        fetch(32'h3463_8000);
        cyc();
        check("ori_alu_b", 64'(alu_b), 64'h0000_0000_0000_8000);
        check("ori_alu_op", 64'(alu_op), E_OR);
        cyc();
        check("ori_reg_w", 64'(reg_w), 64'd3);
        check("ori_we", 64'(reg_write_en), 64'd1);
        cyc();

        // ADD $0,$1,$2: write to $0 suppressed
        fetch(32'h0022_0020);
        reg_out_2 = 64'h1234;
        cyc();
        check("add0_alu_b", 64'(alu_b), 64'h1234);
        check("add0_alu_op", 64'(alu_op), E_ADD);
        cyc();
        check("add0_wb_state", 64'(state_dbg), S_WB);
        check("add0_reg_w", 64'(reg_w), 64'd0);
        check("add0_we", 64'(reg_write_en), 64'd0);
        cyc();

        // SLTU $7,$1,$2
        fetch(32'h0022_382B);
        cyc();
        check("sltu_alu_op", 64'(alu_op), E_SLTU);
        cyc();
        check("sltu_reg_w", 64'(reg_w), 64'd7);
        check("sltu_we", 64'(reg_write_en), 64'd1);
        cyc();

        // LUI $2,0x8001: shifted and sign-extended
        fetch(32'h3C02_8001);
        cyc();
        check("lui_alu_b", 64'(alu_b), 64'hFFFF_FFFF_8001_0000);
        cyc();
        cyc();

        // LW $4,-8($1) with dmem_ready after three wait cycles
        fetch(32'h8C24_FFF8);
        dmem_ready = 1'b1;
        cyc();
        check("lw_exec_state", 64'(state_dbg), S_EXEC);
        check("lw_alu_b", 64'(alu_b), 64'hFFFF_FFFF_FFFF_FFF8);
        check("lw_exec_dmem_req", 64'(dmem_req), 64'd0);
        dmem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            #1;
            check("lw_mem_state", 64'(state_dbg), S_MEM);
            check("lw_dmem_req", 64'(dmem_req), 64'd1);
            check("lw_dmem_we", 64'(dmem_we), 64'd0);
            cyc();
        end
        dmem_ready = 1'b0;
        #1;
        check("lw_wb_state", 64'(state_dbg), S_WB);
        check("lw_wb_sel", 64'(wb_sel), 64'd1);
        check("lw_reg_w", 64'(reg_w), 64'd4);
        check("lw_we", 64'(reg_write_en), 64'd1);
        cyc();
        check("lw_back_fetch", 64'(state_dbg), S_FETCH);

        // SW $4,16($1): no write-back
        fetch(32'hAC24_0010);
        cyc();
        check("sw_alu_b", 64'(alu_b), 64'd16);
        cyc();
        dmem_ready = 1'b1;
        #1;
        check("sw_dmem_req", 64'(dmem_req), 64'd1);
        check("sw_dmem_we", 64'(dmem_we), 64'd1);
        cyc();
        dmem_ready = 1'b0;
        #1;
        check("sw_back_fetch", 64'(state_dbg), S_FETCH);
        check("sw_no_we", 64'(reg_write_en), 64'd0);

        // BEQ taken
        fetch(32'h1022_0003);
        reg_out_2 = 64'd5;
        alu_zero  = 1'b1;
        cyc();
        check("beq_alu_op", 64'(alu_op), E_SUB);
        check("beq_alu_b", 64'(alu_b), 64'd5);
        check("beq_pc_write", 64'(pc_write), 64'd1);
        check("beq_pc_src", 64'(pc_src), 64'd1);
        cyc();
        check("beq_back_fetch", 64'(state_dbg), S_FETCH);

        // BNE not taken (alu_zero = 1)
        fetch(32'h1422_0003);
        cyc();
        check("bne_nt_pc_write", 64'(pc_write), 64'd0);
        check("bne_nt_pc_src", 64'(pc_src), 64'd0);
        cyc();
        check("bne_nt_back_fetch", 64'(state_dbg), S_FETCH);

        // BNE taken (alu_zero = 0)
        fetch(32'h1422_0003);
        alu_zero = 1'b0;
        cyc();
        check("bne_t_pc_write", 64'(pc_write), 64'd1);
        check("bne_t_pc_src", 64'(pc_src), 64'd1);
        cyc();

        // Illegal opcode 0x3F
        fetch(32'hFC00_0000);
        check("ill_pulse", 64'(illegal), 64'd1);
        check("ill_no_we", 64'(reg_write_en), 64'd0);
        cyc();
        check("ill_back_fetch", 64'(state_dbg), S_FETCH);
        check("ill_pulse_end", 64'(illegal), 64'd0);

        // Unknown R-type funct (SLL encoding)
        fetch(32'h0000_0000);
        check("ill_funct", 64'(illegal), 64'd1);
        cyc();

        // Reset during the MEM wait abandons the load
        fetch(32'h8C24_FFF8);
        cyc();
        cyc();
        check("rstmem_dmem_req", 64'(dmem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstmem_gated_req", 64'(dmem_req), 64'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("rstmem_state", 64'(state_dbg), S_FETCH);
        check("rstmem_dmem_req_next", 64'(dmem_req), 64'd0);
        check("rstmem_no_we", 64'(reg_write_en), 64'd0);
        check("rstmem_imem_req", 64'(imem_req), 64'd1);
        cyc();
        check("rstmem_fetch_wait", 64'(state_dbg), S_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
